// File: rtl/fcvt_pkg.sv
// -----------------------------------------------------------------------------
// fcvt_pkg -- definitions shared by the fcvt conversion block.
//
// Holds the mode encodings carried on rs2[1:0], the IEEE-754 binary32 field
// layout, the exponent bias, and the integer saturation constants used by
// the float->int paths.
// -----------------------------------------------------------------------------
package fcvt_pkg;

  // Conversion modes as decoded from rs2[1:0].
  typedef enum logic [1:0] {
    W_S  = 2'b00,  // binary32 -> signed int32
    WU_S = 2'b01,  // binary32 -> unsigned int32
    S_W  = 2'b10,  // signed int32 -> binary32
    S_WU = 2'b11   // unsigned int32 -> binary32
  } mode_e;

  // binary32 field widths and exponent bias.
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Integer saturation values.
  localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Biased exponents of interesting magnitudes.
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(BIAS);          // 2^0
  localparam logic [EXP_W-1:0] EXP_LSB0 = EXP_W'(BIAS + MAN_W);  // 2^23: significand LSB weighs 1
  localparam logic [EXP_W-1:0] EXP_2_31 = EXP_W'(BIAS + 31);     // 2^31
  localparam logic [EXP_W-1:0] EXP_2_32 = EXP_W'(BIAS + 32);     // 2^32
  localparam logic [EXP_W-1:0] EXP_SPEC = '1;                    // inf / NaN

endpackage

// File: rtl/fcvt_lzc.sv
// -----------------------------------------------------------------------------
// fcvt_lzc -- combinational 32-bit leading-zero counter.
//
// Ports:
//   data_i   in  32  value to scan
//   count_o  out 6   number of zeros above the most significant set bit;
//                    32 when data_i is zero
// -----------------------------------------------------------------------------
module fcvt_lzc (
  input  logic [31:0] data_i,
  output logic [5:0]  count_o
);

  logic found;

  // Scan from the MSB down; the first set bit freezes the count.
  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    count_o = 6'd32;
    found   = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        count_o = 6'(31 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcvt.sv
// -----------------------------------------------------------------------------
// fcvt -- single-cycle binary32 <-> int32 converter.
//
// Ports:
//   clk     in  1     rising-edge clock
//   resetn  in  1     synchronous reset, ACTIVE-HIGH despite the name
//   rs1     in  FLEN  source operand (binary32 or int32 depending on mode)
//   rs2     in  FLEN  mode select; only rs2[1:0] is decoded
//   out     out FLEN  registered result, one cycle after the operands
//
// Float->int truncates toward zero and saturates (NaN goes to the positive
// limit). Int->float rounds to nearest, ties to even.
//
// Configuration: define FCVT_UNSIGNED_EN to build the unsigned modes
// (WU.S, S.WU). Without it the unsigned logic is not built, mode 01 acts as
// W.S and mode 11 acts as S.W.
//
// FLEN is fixed at 32; other values are not supported.
// -----------------------------------------------------------------------------
module fcvt
  import fcvt_pkg::*;
#(
  parameter int FLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  output logic [FLEN-1:0] out
);

  // ---------------------------------------------------------------------------
  // Mode decode
  // ---------------------------------------------------------------------------
  mode_e mode;
  logic  i2f_signed;

  always_comb begin
`ifdef FCVT_UNSIGNED_EN
    mode       = mode_e'(rs2[1:0]);
    i2f_signed = (mode == S_W);
`else
    // Unsigned modes fold onto their signed counterparts.
    if (rs2[1]) mode = S_W;
    else        mode = W_S;
    i2f_signed = 1'b1;
`endif
  end

  // Upper mode bits are don't-care by definition.
  logic unused_rs2;
`ifdef FCVT_UNSIGNED_EN
  assign unused_rs2 = ^rs2[FLEN-1:2];
`else
  assign unused_rs2 = ^{rs2[FLEN-1:2], rs2[0]};
`endif

  // ---------------------------------------------------------------------------
  // Float -> int
  // ---------------------------------------------------------------------------
  fp32_t       f_in;
  logic        f_nan;
  logic        f_below_one;
  logic        f_ge_2_31;
  logic [31:0] f_mag;        // truncated |x|, meaningful for 2^0 <= |x| < 2^32
  logic [31:0] f2i_w;

  assign f_in        = fp32_t'(rs1);
  assign f_nan       = (f_in.exp == EXP_SPEC) && (f_in.man != '0);
  assign f_below_one = (f_in.exp < EXP_ONE);
  // Infinity has the all-ones exponent and therefore lands in both
  // saturation ranges without a separate check.
  assign f_ge_2_31   = (f_in.exp >= EXP_2_31);

  // Align the significand so its binary point sits at bit 0. Shifting right
  // drops the fraction bits, which is exactly truncation toward zero.
  always_comb begin
    f_mag = '0;
    if (f_in.exp <= EXP_LSB0)
      f_mag = {8'h00, 1'b1, f_in.man} >> (EXP_LSB0 - f_in.exp);
    else
      f_mag = {8'h00, 1'b1, f_in.man} << (f_in.exp - EXP_LSB0);
  end

  // W.S: the negative limit also covers -2^31 exactly, which is representable.
  always_comb begin
    f2i_w = '0;
    if (f_nan)            f2i_w = INT_MAX;
    else if (f_below_one) f2i_w = '0;
    else if (f_in.sign)   f2i_w = f_ge_2_31 ? INT_MIN : (-f_mag);
    else                  f2i_w = f_ge_2_31 ? INT_MAX : f_mag;
  end

`ifdef FCVT_UNSIGNED_EN
  logic        f_ge_2_32;
  logic [31:0] f2i_wu;

  assign f_ge_2_32 = (f_in.exp >= EXP_2_32);

  // WU.S: anything negative is either above -1 (truncates to 0) or at/below
  // -1 (saturates to 0), so the sign alone selects zero.
  always_comb begin
    f2i_wu = '0;
    if (f_nan)            f2i_wu = UINT_MAX;
    else if (f_below_one) f2i_wu = '0;
    else if (f_in.sign)   f2i_wu = '0;
    else                  f2i_wu = f_ge_2_32 ? UINT_MAX : f_mag;
  end
`endif

  // ---------------------------------------------------------------------------
  // Int -> float
  // ---------------------------------------------------------------------------
  logic        i_neg;
  logic [31:0] i_mag;
  logic [5:0]  i_lzc;
  logic [31:0] i_norm;       // magnitude with its leading one at bit 31
  logic [7:0]  i_exp;
  logic        i_round_up;
  logic [30:0] i_rounded;    // {exponent, mantissa} after rounding
  logic [31:0] i2f;

  // INT_MIN negates to itself, which is already the correct magnitude 2^31.
  assign i_neg = i2f_signed && rs1[31];
  assign i_mag = i_neg ? (-rs1) : rs1;

  fcvt_lzc u_lzc (
    .data_i  (i_mag),
    .count_o (i_lzc)
  );

  assign i_norm = i_mag << i_lzc;
  assign i_exp  = EXP_2_31 - {2'b00, i_lzc};

  // Bits 30:8 become the mantissa; bit 7 is the guard bit and bits 6:0 are
  // sticky. On an exact tie, round up only when the kept LSB is odd.
  assign i_round_up = i_norm[7] && ((|i_norm[6:0]) || i_norm[8]);

  // Exponent and mantissa are added as one field so that a mantissa
  // overflow on rounding carries straight into the exponent.
  assign i_rounded = {i_exp, i_norm[30:8]} + {30'd0, i_round_up};

  // A zero magnitude has no leading one and must map to +0.
  assign i2f = i_lzc[5] ? 32'h0000_0000 : {i_neg, i_rounded};

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  logic [31:0] out_d;
  logic [31:0] out_q;

  always_comb begin
    out_d = '0;
    if (resetn) begin
      out_d = '0;
    end else begin
      unique case (mode)
        W_S:     out_d = f2i_w;
        S_W:     out_d = i2f;
`ifdef FCVT_UNSIGNED_EN
        WU_S:    out_d = f2i_wu;
        S_WU:    out_d = i2f;
`endif
        default: out_d = '0;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its input as it stood before the clock edge.
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_fcvt.sv
// -----------------------------------------------------------------------------
// tb_fcvt -- self-checking bench for fcvt.
//
// A driver issues one operation per cycle and pushes the model's expected
// result into a scoreboard queue; a monitor pops one entry after every clock
// edge that followed an issued operation and compares it with the DUT output.
// The model works on real numbers and integer arithmetic rather than on bit
// fields. Define FCVT_UNSIGNED_EN for both RTL and bench to cover the
// unsigned modes.
// -----------------------------------------------------------------------------
module tb_fcvt;

`ifdef FCVT_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] out;
  logic        issue;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  fcvt #(.FLEN(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .rs1    (rs1),
    .rs2    (rs2),
    .out    (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else        repeat (-e) p = p / 2.0;
    return p;
  endfunction

  // Value of a binary32 word as a real; infinity becomes a huge finite value.
  function automatic real fp_value(input logic [31:0] a);
    int  ex = int'(a[30:23]);
    real v;
    if (ex == 255)    v = 1.0e300;
    else if (ex == 0) v = real'(a[22:0]) * pow2(-149);
    else              v = real'(32'h0080_0000 + {9'd0, a[22:0]}) * pow2(ex - 150);
    return a[31] ? -v : v;
  endfunction

  function automatic logic [31:0] model_f2i(input logic [31:0] a, input bit uns);
    real x;
    real t;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    x = fp_value(a);
    if (uns) begin
      if (x >= 4294967296.0) return 32'hFFFF_FFFF;
      if (x < 0.0)           return 32'h0000_0000;
      return 32'(longint'($floor(x)));
    end
    if (x >= 2147483648.0)  return 32'h7FFF_FFFF;
    if (x <= -2147483648.0) return 32'h8000_0000;
    t = (x >= 0.0) ? $floor(x) : -$floor(-x);
    return 32'(longint'(t));
  endfunction

  function automatic logic [31:0] model_i2f(input logic [31:0] a, input bit sgn);
    longint m;
    longint q;
    longint r;
    longint half;
    int     e;
    bit     s = 1'b0;
    if (sgn && a[31]) begin
      s = 1'b1;
      m = 64'h1_0000_0000 - longint'(a);
    end else begin
      m = longint'(a);
    end
    if (m == 0) return 32'h0000_0000;
    e = 32;
    while (!m[e]) e--;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      q    = m >> (e - 23);
      r    = m - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic r, input logic [31:0] a, input logic [1:0] m);
    logic [1:0] em;
    if (r) return 32'h0000_0000;
    em = UNS_EN ? m : {m[1], 1'b0};
    case (em)
      2'b00:   return model_f2i(a, 1'b0);
      2'b01:   return model_f2i(a, 1'b1);
      2'b10:   return model_i2f(a, 1'b1);
      default: return model_i2f(a, 1'b0);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic send(input logic r, input logic [31:0] a, input logic [1:0] m, input string name);
    logic [31:0] hi;
    @(negedge clk);
    hi     = $urandom();
    resetn = r;
    rs1    = a;
    rs2    = {hi[31:2], m};
    issue  = 1'b1;
    sb_q.push_back(model(r, a, m));
    name_q.push_back($sformatf("%s a=%08h m=%0d r=%0b", name, a, m, r));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin : monitor
    logic v;
    v = issue;
    #1;
    if (v) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got %08h expected no output", out);
      end else begin
        check(name_q.pop_front(), out, sb_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam int N_DIR = 24;
  localparam logic [31:0] DIR_A [N_DIR] = '{
    32'hC020_0000, 32'hBF00_0000, 32'h7FC0_0000, 32'h7FC0_0000,
    32'h4F80_0000, 32'hFF80_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'h8000_0000, 32'h0100_0001, 32'h0100_0003, 32'hCF00_0000,
    32'h4F00_0000, 32'h4F7F_FFFF, 32'h0000_0000, 32'h0000_0001,
    32'h3F7F_FFFF, 32'hBF80_0000, 32'h7F80_0000, 32'h4F80_0000,
    32'h00FF_FFFF, 32'h7FFF_FFFF, 32'hCF00_0001, 32'h8000_0000
  };
  localparam logic [1:0] DIR_M [N_DIR] = '{
    2'd0, 2'd1, 2'd0, 2'd1,
    2'd0, 2'd0, 2'd2, 2'd3,
    2'd2, 2'd2, 2'd2, 2'd0,
    2'd0, 2'd1, 2'd2, 2'd0,
    2'd0, 2'd1, 2'd1, 2'd1,
    2'd3, 2'd2, 2'd0, 2'd3
  };

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [1:0]  m;
    logic        r;

    resetn = 1'b1;
    rs1    = '0;
    rs2    = '0;
    issue  = 1'b0;

    // Reset with arbitrary operands, then the first result right after release.
    send(1'b1, $urandom(), 2'd2, "reset");
    send(1'b1, 32'h3FC0_0000, 2'd0, "reset");
    send(1'b0, 32'h3FC0_0000, 2'd0, "first_after_reset");

    for (int i = 0; i < N_DIR; i++) send(1'b0, DIR_A[i], DIR_M[i], "directed");

    // Reset must win over a conversion presented in the same cycle.
    send(1'b1, 32'h4B00_0000, 2'd2, "reset_priority");
    send(1'b0, 32'h4B00_0000, 2'd2, "after_mid_reset");

    for (int i = 0; i < 800; i++) begin
      w = $urandom();
      m = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: a = w;
        1: a = {w[31], 8'($urandom_range(118, 165)), w[22:0]};
        2: a = (w[0] ? -(32'(1) << $urandom_range(0, 31)) : (32'(1) << $urandom_range(0, 31)))
               + 32'($urandom_range(0, 7)) - 32'd3;
        default: begin
          case ($urandom_range(0, 5))
            0: a = {w[31], 8'hFF, 23'd0};
            1: a = {w[31], 8'hFF, w[22:1], 1'b1};
            2: a = {w[31], 8'd158, w[22:0]};
            3: a = {w[31], 8'd159, w[22:0]};
            4: a = {w[31], 8'd0, w[22:0]};
            default: a = {w[31], 8'd127, 23'd0};
          endcase
        end
      endcase
      send(r, a, m, "rnd");
    end

    @(negedge clk);
    issue = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
